// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, three read ports, scoreboard alloc/pending and ready.
// The master side drives addresses/data/enables; the slave (register file) returns read data and status.
interface regfile_mp_if #(
  parameter int N    = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic          we3;
  logic [AW-1:0] wa3;
  logic [N-1:0]  wd3;
  logic          we4;
  logic [AW-1:0] wa4;
  logic [N-1:0]  wd4;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] ra3;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic [N-1:0]  rd3;
  logic          alloc_en;
  logic [AW-1:0] alloc_a;
  logic          pend1;
  logic          pend2;
  logic          pend3;
  logic          ready;

  modport master (
    output we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, ra3, alloc_en, alloc_a,
    input  rd1, rd2, rd3, pend1, pend2, pend3, ready
  );

  modport slave (
    input  we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, ra3, alloc_en, alloc_a,
    output rd1, rd2, rd3, pend1, pend2, pend3, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// N x NREG register file: 2 write ports (B has priority), 3 forwarding read ports, XZR at NREG-1,
// init sequencer (reg[i] <= i after reset). Pending-write scoreboard built when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp #(
  parameter int N    = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZR = AW'(NREG - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mem [NREG];
  logic          run;
  logic          wr3, wr4;

  assign run = (state_q == RUN);
  assign wr3 = run && bus.we3 && (bus.wa3 != ZR);
  assign wr4 = run && bus.we4 && (bus.wa4 != ZR);
  assign bus.ready = run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer leaves INIT on the edge that writes the last index, so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (cnt_q == ZR) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Array has no reset; port B is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q] <= N'(cnt_q);
    end else begin
      if (wr3) mem[bus.wa3] <= bus.wd3;
      if (wr4) mem[bus.wa4] <= bus.wd4;
    end
  end

  function automatic logic [N-1:0] rd_fwd(input logic [AW-1:0] ra);
    logic [N-1:0] v;
    if (!run || ra == ZR)             v = '0;
    else if (wr4 && bus.wa4 == ra)    v = bus.wd4;
    else if (wr3 && bus.wa3 == ra)    v = bus.wd3;
    else                              v = mem[ra];
    return v;
  endfunction

  always_comb begin
    bus.rd1 = rd_fwd(bus.ra1);
    bus.rd2 = rd_fwd(bus.ra2);
    bus.rd3 = rd_fwd(bus.ra3);
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] pend_q;

  // Set beats clear when alloc and a write hit the same register in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else if (run) begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.alloc_en && bus.alloc_a == AW'(i) && AW'(i) != ZR)
          pend_q[i] <= 1'b1;
        else if ((wr3 && bus.wa3 == AW'(i)) || (wr4 && bus.wa4 == AW'(i)))
          pend_q[i] <= 1'b0;
      end
    end
  end

  function automatic logic pend_of(input logic [AW-1:0] ra);
    return run && pend_q[ra] && !(wr3 && bus.wa3 == ra) && !(wr4 && bus.wa4 == ra);
  endfunction

  always_comb begin
    bus.pend1 = pend_of(bus.ra1);
    bus.pend2 = pend_of(bus.ra2);
    bus.pend3 = pend_of(bus.ra3);
  end
`else
  logic unused_sb;
  assign unused_sb = ^{bus.alloc_en, bus.alloc_a};
  assign bus.pend1 = 1'b0;
  assign bus.pend2 = 1'b0;
  assign bus.pend3 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model (edge counter + array) checked every
// negedge, plus literal expectations for init, forwarding, port priority, XZR, scoreboard, reset.
module tb_regfile_mp;
  localparam int N    = 64;
  localparam int NREG = 32;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.N(N), .NREG(NREG)) bus ();
  regfile_mp #(.N(N), .NREG(NREG)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [63:0] m_reg  [NREG];
  bit          m_pend [NREG];
  int          m_edges = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ready after NREG edges since reset release; then plain array semantics.
  function automatic bit m_ready();
    return reset_n && (m_edges >= NREG);
  endfunction

  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (!m_ready() || ra == 5'd31) return 64'd0;
    if (bus.we4 && bus.wa4 == ra) return bus.wd4;
    if (bus.we3 && bus.wa3 == ra) return bus.wd3;
    return m_reg[ra];
  endfunction

  function automatic bit exp_pend(input logic [4:0] ra);
    if (!SB || !m_ready() || ra == 5'd31) return 1'b0;
    if ((bus.we4 && bus.wa4 == ra) || (bus.we3 && bus.wa3 == ra)) return 1'b0;
    return m_pend[ra];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges <= 0;
      for (int i = 0; i < NREG; i++) m_pend[i] <= 1'b0;
    end else if (m_edges < NREG) begin
      m_reg[m_edges] <= 64'(m_edges);
      m_edges <= m_edges + 1;
    end else begin
      if (bus.we3 && bus.wa3 != 5'd31) begin
        m_reg[bus.wa3]  <= bus.wd3;
        m_pend[bus.wa3] <= 1'b0;
      end
      if (bus.we4 && bus.wa4 != 5'd31) begin
        m_reg[bus.wa4]  <= bus.wd4;
        m_pend[bus.wa4] <= 1'b0;
      end
      if (SB && bus.alloc_en && bus.alloc_a != 5'd31) m_pend[bus.alloc_a] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd1",   bus.rd1, exp_rd(bus.ra1));
      chk("rd2",   bus.rd2, exp_rd(bus.ra2));
      chk("rd3",   bus.rd3, exp_rd(bus.ra3));
      chk("pend1", 64'(bus.pend1), 64'(exp_pend(bus.ra1)));
      chk("pend2", 64'(bus.pend2), 64'(exp_pend(bus.ra2)));
      chk("pend3", 64'(bus.pend3), 64'(exp_pend(bus.ra3)));
      chk("ready", 64'(bus.ready), 64'(m_ready()));
    end
  end

  task automatic idle();
    bus.we3 = 1'b0; bus.wa3 = '0; bus.wd3 = '0;
    bus.we4 = 1'b0; bus.wa4 = '0; bus.wd4 = '0;
    bus.ra1 = '0; bus.ra2 = '0; bus.ra3 = '0;
    bus.alloc_en = 1'b0; bus.alloc_a = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_init();
    for (int i = 1; i <= NREG; i++) begin
      step();
      if (i == NREG - 1) chk("ready_before", 64'(bus.ready), 64'd0);
      if (i == NREG)     chk("ready_after",  64'(bus.ready), 64'd1);
    end
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(25, 31));
  endfunction

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.we3 = 1'($urandom_range(0, 1)); bus.wa3 = pick(); bus.wd3 = {$urandom, $urandom};
      bus.we4 = 1'($urandom_range(0, 1)); bus.wa4 = pick(); bus.wd4 = {$urandom, $urandom};
      bus.ra1 = pick(); bus.ra2 = pick(); bus.ra3 = pick();
      bus.alloc_en = ($urandom_range(0, 2) == 0); bus.alloc_a = pick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_rd1"},   bus.rd1, 64'd0);
    chk({tag, "_rd2"},   bus.rd2, 64'd0);
    chk({tag, "_pend1"}, 64'(bus.pend1), 64'd0);
    chk({tag, "_ready"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    idle();
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    wait_init();

    bus.ra1 = 5'd5; bus.ra2 = 5'd17; bus.ra3 = 5'd31;
    #1;
    chk("init_r5",  bus.rd1, 64'd5);
    chk("init_r17", bus.rd2, 64'd17);
    chk("init_xzr", bus.rd3, 64'd0);

    step(); idle();
    bus.we3 = 1'b1; bus.wa3 = 5'd4; bus.wd3 = 64'hDEAD; bus.ra1 = 5'd4;
    #1 chk("fwd_same", bus.rd1, 64'hDEAD);
    step(); bus.we3 = 1'b0;
    #1 chk("fwd_after", bus.rd1, 64'hDEAD);

    step(); idle();
    bus.we3 = 1'b1; bus.we4 = 1'b1; bus.wa3 = 5'd9; bus.wa4 = 5'd9;
    bus.wd3 = 64'h11; bus.wd4 = 64'h22; bus.ra2 = 5'd9;
    #1 chk("prio_same", bus.rd2, 64'h22);
    step(); idle(); bus.ra2 = 5'd9;
    #1 chk("prio_after", bus.rd2, 64'h22);

    step(); idle();
    bus.we4 = 1'b1; bus.wa4 = 5'd31; bus.wd4 = 64'hFF; bus.ra1 = 5'd31;
    #1 chk("xzr_same", bus.rd1, 64'd0);
    step(); bus.we4 = 1'b0;
    #1 chk("xzr_after", bus.rd1, 64'd0);
    step();
    #1 chk("xzr_later", bus.rd1, 64'd0);

    step(); idle();
    bus.we3 = 1'b0; bus.wa3 = 5'd6; bus.wd3 = 64'h123; bus.ra1 = 5'd6;
    #1 chk("no_fwd_without_we", bus.rd1, 64'd6);

    step(); idle();
    bus.alloc_en = 1'b1; bus.alloc_a = 5'd7; bus.ra1 = 5'd7;
    #1 chk("sb_alloc_same", 64'(bus.pend1), 64'd0);
    step(); bus.alloc_en = 1'b0;
    #1 chk("sb_alloc_next", 64'(bus.pend1), 64'(SB));
    bus.we3 = 1'b1; bus.wa3 = 7; bus.wd3 = 64'h77;
    #1 chk("sb_write_comb", 64'(bus.pend1), 64'd0);
    step(); bus.we3 = 1'b0;
    #1 chk("sb_write_after", 64'(bus.pend1), 64'd0);
    step();
    bus.alloc_en = 1'b1; bus.alloc_a = 5'd7; bus.we4 = 1'b1; bus.wa4 = 5'd7; bus.wd4 = 64'h5;
    #1 chk("sb_both_comb", 64'(bus.pend1), 64'd0);
    step(); idle(); bus.ra1 = 5'd7;
    #1 chk("sb_both_after", 64'(bus.pend1), 64'(SB));
    chk("sb_both_data", bus.rd1, 64'h5);
    bus.alloc_en = 1'b1; bus.alloc_a = 5'd31;
    step(); idle(); bus.ra2 = 5'd31;
    #1 chk("sb_xzr", 64'(bus.pend2), 64'd0);

    step(); idle();
    bus.we3 = 1'b1; bus.wa3 = 5'd3; bus.wd3 = 64'hBAD;
    step(); idle(); bus.ra1 = 5'd3;
    #1 chk("r3_overwritten", bus.rd1, 64'hBAD);

    rand_cycles(1500);

    step(); idle(); bus.ra1 = 5'd3; bus.ra2 = 5'd5;
    reset_n = 1'b0;
    check_reset_outputs("rst_run");
    step(); step();
    reset_n = 1'b1;
    wait_init();
    bus.ra1 = 5'd3;
    #1 chk("r3_restored", bus.rd1, 64'd3);

    step(); idle(); reset_n = 1'b0;
    step(); reset_n = 1'b1;
    repeat (10) step();
    bus.ra1 = 5'd3; bus.ra2 = 5'd5;
    reset_n = 1'b0;
    check_reset_outputs("rst_init");
    step();
    reset_n = 1'b1;
    wait_init();
    bus.ra1 = 5'd3;
    #1 chk("r3_after_init_rst", bus.rd1, 64'd3);

    rand_cycles(800);
    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
